mem_port_arbiter: RTL

- Shares the single memory port (memory2c instance) between the core's instruction-fetch path and its data load/store path.
- Arbitrates contention round-robin and allows one outstanding access at a time.
- Sequences the fixed memory read latency and returns read data to the winning requester with a one-cycle valid pulse.
- Sits between the fetch/PC logic, the load/store unit and memory, so fetch and data can use one memory.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store with
// round-robin arbitration and a single outstanding access of fixed read latency.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_en_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    if ((MEM_LAT < 1) || (MEM_LAT > 7)) begin : g_lat_check
        $error("mem_port_arbiter: MEM_LAT must be in the range 1..7");
    end

    typedef enum logic {IDLE, WAIT} state_e;
    typedef enum logic {OWN_IF, OWN_D} owner_e;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    owner_e            lastOwner_q, lastOwner_d;
    owner_e            rdOwner_q, rdOwner_d;
    logic              ifRvalid_q, dRvalid_q;
    logic [DATA_W-1:0] ifRdata_q, dRdata_q;

    logic   grantIf, grantD, issueRead, sample;
    owner_e sampleOwner;

    // Grants are gated by reset so nothing leaves the block while rst_ni is low.
    always_comb begin
        grantIf = 1'b0;
        grantD  = 1'b0;
        if (rst_ni && (state_q == IDLE)) begin
            grantIf = if_req_i && (!d_req_i || (lastOwner_q == OWN_D));
            grantD  = d_req_i && (!if_req_i || (lastOwner_q == OWN_IF));
        end
        issueRead = grantIf || (grantD && !d_we_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            lastOwner_q <= OWN_D;
            rdOwner_q   <= OWN_D;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lastOwner_q <= lastOwner_d;
            rdOwner_q   <= rdOwner_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lastOwner_d = lastOwner_q;
        rdOwner_d   = rdOwner_q;
        case (state_q)
            IDLE: begin
                if (issueRead && (MEM_LAT > 1)) begin
                    state_d = WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grantIf) begin
            lastOwner_d = OWN_IF;
        end else if (grantD) begin
            lastOwner_d = OWN_D;
        end
        if (issueRead) begin
            rdOwner_d = grantIf ? OWN_IF : OWN_D;
        end
    end

    // With a one-cycle latency the data is captured in the issue cycle itself.
    always_comb begin
        if (MEM_LAT == 1) begin
            sample      = issueRead;
            sampleOwner = grantIf ? OWN_IF : OWN_D;
        end else begin
            sample      = (state_q == WAIT) && (cnt_q == 3'd1);
            sampleOwner = rdOwner_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ifRvalid_q <= 1'b0;
            dRvalid_q  <= 1'b0;
            ifRdata_q  <= '0;
            dRdata_q   <= '0;
        end else begin
            ifRvalid_q <= sample && (sampleOwner == OWN_IF);
            dRvalid_q  <= sample && (sampleOwner == OWN_D);
            if (sample && (sampleOwner == OWN_IF)) begin
                ifRdata_q <= mem_rdata_i;
            end
            if (sample && (sampleOwner == OWN_D)) begin
                dRdata_q <= mem_rdata_i;
            end
        end
    end

    always_comb begin
        if_gnt_o    = grantIf;
        d_gnt_o     = grantD;
        mem_en_o    = grantIf || grantD;
        mem_wr_o    = grantD && d_we_i;
        mem_addr_o  = grantIf ? if_addr_i : (grantD ? d_addr_i : '0);
        mem_wdata_o = grantD ? d_wdata_i : '0;
        busy_o      = (state_q == WAIT);
        if_rvalid_o = ifRvalid_q;
        d_rvalid_o  = dRvalid_q;
        if_rdata_o  = ifRdata_q;
        d_rdata_o   = dRdata_q;
    end

endmodule
